irq_pending_ctrl: RTL and testbench
===================================

Name: irq_pending_ctrl

Overview:
- Interrupt pending/priority stage in the risc32i core; sits directly upstream of Encoder_16.
- Detects rising edges on N interrupt lines, latches them as pending, and applies an enable mask.
- Presents the highest-priority eligible request to the CPU as a stable one-hot vector under a valid/ack handshake.
- Encoder_16 consumes req_onehot and converts it to a 4-bit vector index.

Parameters:
- N, 16, number of interrupt lines; req_onehot width. Must be 16 when driving Encoder_16.

Ports:
- clk  input  1  single core clock, rising edge
- rst_n  input  1  synchronous, active-low reset
- irq_in  input  N  raw interrupt lines, already synchronous to clk, level form
- mask_we  input  1  enable-mask write strobe
- mask_wdata  input  N  new enable mask (1 = line enabled)
- mask_q  output  N  current enable mask
- pending_q  output  N  latched pending bits, masked and unmasked
- req_valid  output  1  a request is being presented
- req_onehot  output  N  one-hot request vector, feeds Encoder_16
- req_ack  input  1  CPU accepts the presented request

Behaviour:
- Reset is synchronous, active-low, sampled on the clk rising edge. While rst_n=0:
  - pending_q=0, mask_q=0, req_valid=0, req_onehot=0, FSM=IDLE.
  - irq_prev (internal edge-detect register) = all ones, so a line already high at reset release does not count as an edge.
- Reset asserted mid-handshake discards the presented request and all pending bits.
- Edge detect: rise[i] = irq_in[i] & ~irq_prev[i]. irq_prev <= irq_in on every edge.
- Pending update, per bit per edge: pending[i] <= rise[i] | (pending[i] & ~clr[i]).
  - clr is the one-hot of the request being acked this edge.
  - If set and clear hit the same bit on the same edge, set wins and the bit stays pending.
- Mask: mask_q <= mask_wdata on an edge with mask_we=1.
  - Masked lines still latch into pending_q but are not eligible.
  - eligible = pending_q & mask_q, using the registered values.
- Priority: the lowest index wins (bit 0 highest). Selection is eligible & (~eligible + 1).
- FSM states:
  - IDLE: if eligible != 0 → HOLD, and register req_onehot = selection, req_valid = 1. Otherwise stay in IDLE with outputs 0.
  - HOLD: req_onehot and req_valid are held stable regardless of new higher-priority arrivals or mask changes.
  - HOLD with req_ack=1 on an edge: the held bit is cleared from pending, FSM → IDLE, req_valid=0, req_onehot=0.
- req_ack while in IDLE is ignored; no state change.
- Latency:
  - irq_in rises before edge E0 → pending bit set at E0 → req_valid=1 after E1.
  - Ack at edge Ek → next eligible request has req_valid=1 after Ek+1. There is always one idle cycle between requests.
- Invariant: req_onehot has exactly one bit set when req_valid=1, and is all zeros otherwise. Encoder_16 output is therefore meaningful only when req_valid=1.
- A level held high produces one edge only; re-assertion requires a low cycle.

Decomposition:
- Shared package irq_pkg:
  - IRQ_N = 16.
  - FSM state typedef {IDLE, HOLD}.
  - IRQ_ALL_ONES reset constant for irq_prev.
- One natural sub-module: irq_prio_pick. It is purely combinational, N-bit eligible in → lowest-set-bit one-hot out. It is reused later by the bus arbiter.

Test Plan:
- Reset release with irq_in=16'h0003 held high, mask 16'hFFFF written → pending_q stays 0 and req_valid stays 0 for 10 cycles.
- Mask 16'hFFFF, pulse irq_in[5] for 1 cycle at E0 → pending_q=16'h0020 after E0. After E1, req_valid=1 and req_onehot=16'h0020 (Encoder_16 gives 5). Ack at E2 → pending_q=0, req_valid=0.
- Pulse bits 9 and 2 on the same edge → 16'h0004 is presented first. After its ack, one idle cycle, then 16'h0200.
- While 16'h0200 is held, pulse bit 0 → req_onehot stays 16'h0200 until ack, then 16'h0001 is presented.
- Mask 16'hFFF7, pulse bit 3 → pending_q=16'h0008 and req_valid stays 0. Write mask 16'hFFFF → req_valid=1 with req_onehot=16'h0008 two edges after the write.
- In HOLD on bit 4, edge-ack bit 4 on the same edge a new rise hits bit 4 → pending_q=16'h0010 remains, and it is re-presented after one idle cycle.
- Assert rst_n=0 during HOLD → all outputs 0 on the next edge.

Source files
------------

// File: rtl/irq_pkg.sv
// Shared definitions for the interrupt pending/priority stage.
package irq_pkg;

  localparam int IRQ_N = 16;

  typedef enum logic {
    IDLE = 1'b0,
    HOLD = 1'b1
  } irq_state_t;

  // Edge-detect history is preset high so lines already asserted at reset
  // release are not mistaken for fresh edges.
  localparam logic [IRQ_N-1:0] IRQ_ALL_ONES = '1;

endpackage

// File: rtl/irq_prio_pick.sv
// Lowest-set-bit picker: turns an eligible vector into a one-hot grant,
// with bit 0 as the highest priority. Purely combinational.
module irq_prio_pick #(
  parameter int N = 16
) (
  input  logic [N-1:0] eligible,
  output logic [N-1:0] onehot
);

  // Two's-complement trick isolates the lowest set bit.
  assign onehot = eligible & (~eligible + N'(1));

endmodule

// File: rtl/irq_pending_ctrl.sv
// Interrupt pending/priority stage: rising-edge capture into pending bits,
// enable masking, and a held one-hot request under a valid/ack handshake.
module irq_pending_ctrl
  import irq_pkg::*;
#(
  parameter int N = IRQ_N
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [N-1:0] irq_in,
  input  logic         mask_we,
  input  logic [N-1:0] mask_wdata,
  output logic [N-1:0] mask_q,
  output logic [N-1:0] pending_q,
  output logic         req_valid,
  output logic [N-1:0] req_onehot,
  input  logic         req_ack
);

  irq_state_t   state_q;
  irq_state_t   state_d;
  logic [N-1:0] irq_prev;
  logic [N-1:0] rise;
  logic [N-1:0] eligible;
  logic [N-1:0] selection;
  logic [N-1:0] clr;
  logic [N-1:0] pending_d;
  logic [N-1:0] onehot_d;
  logic         valid_d;

  assign rise     = irq_in & ~irq_prev;
  assign eligible = pending_q & mask_q;

  irq_prio_pick #(.N(N)) u_pick (
    .eligible (eligible),
    .onehot   (selection)
  );

  // Next state and request outputs; the presented request is frozen in HOLD.
  always_comb begin
    state_d  = state_q;
    onehot_d = req_onehot;
    valid_d  = req_valid;
    clr      = '0;
    case (state_q)
      IDLE: begin
        if (eligible != '0) begin
          state_d  = HOLD;
          onehot_d = selection;
          valid_d  = 1'b1;
        end else begin
          onehot_d = '0;
          valid_d  = 1'b0;
        end
      end
      HOLD: begin
        if (req_ack) begin
          clr      = req_onehot;
          state_d  = IDLE;
          onehot_d = '0;
          valid_d  = 1'b0;
        end
      end
      default: begin
        state_d  = IDLE;
        onehot_d = '0;
        valid_d  = 1'b0;
      end
    endcase
  end

  // A new rise on the bit being acked keeps it pending (set beats clear).
  assign pending_d = rise | (pending_q & ~clr);

  // FSM state register with the registered request outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      req_onehot <= '0;
      req_valid  <= 1'b0;
    end else begin
      state_q    <= state_d;
      req_onehot <= onehot_d;
      req_valid  <= valid_d;
    end
  end

  // Edge history, pending latch and enable mask.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      irq_prev  <= IRQ_ALL_ONES;
      pending_q <= '0;
      mask_q    <= '0;
    end else begin
      irq_prev  <= irq_in;
      pending_q <= pending_d;
      if (mask_we) begin
        mask_q <= mask_wdata;
      end
    end
  end

endmodule

// File: tb/tb_irq_pending_ctrl.sv
// Testbench for irq_pending_ctrl: directed scenarios with literal
// expectations plus randomized traffic against a behavioural model.
module tb_irq_pending_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] irq_in;
  logic        mask_we;
  logic [15:0] mask_wdata;
  logic [15:0] mask_q;
  logic [15:0] pending_q;
  logic        req_valid;
  logic [15:0] req_onehot;
  logic        req_ack;

  int checks = 0;
  int errors = 0;
  bit started = 1'b0;

  irq_pending_ctrl #(.N(16)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .irq_in     (irq_in),
    .mask_we    (mask_we),
    .mask_wdata (mask_wdata),
    .mask_q     (mask_q),
    .pending_q  (pending_q),
    .req_valid  (req_valid),
    .req_onehot (req_onehot),
    .req_ack    (req_ack)
  );

  always #5 clk = ~clk;

  // Behavioural model: pending set, mask, previous levels, presented index.
  bit [15:0] m_pend;
  bit [15:0] m_mask;
  bit [15:0] m_prev;
  int        m_p = -1;

  always @(posedge clk) begin
    bit [15:0] rise_v;
    bit [15:0] elig_v;
    bit [15:0] npend;
    int        np;
    if (!rst_n) begin
      m_pend = '0;
      m_mask = '0;
      m_prev = '1;
      m_p    = -1;
    end else begin
      rise_v = irq_in & ~m_prev;
      elig_v = m_pend & m_mask;
      npend  = m_pend;
      np     = m_p;
      if (m_p >= 0) begin
        if (req_ack) begin
          npend[m_p] = 1'b0;
          np = -1;
        end
      end else begin
        for (int i = 15; i >= 0; i--) if (elig_v[i]) np = i;
      end
      npend  = npend | rise_v;
      m_pend = npend;
      m_prev = irq_in;
      if (mask_we) m_mask = mask_wdata;
      m_p = np;
    end
  end

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  // Per-cycle comparison against the model on the inactive edge.
  always @(negedge clk) begin
    if (started) begin
      chk("model_mask", mask_q, m_mask);
      chk("model_pending", pending_q, m_pend);
      chk("model_valid", {15'd0, req_valid}, {15'd0, (m_p >= 0)});
      chk("model_onehot", req_onehot, (m_p >= 0) ? (16'd1 << m_p) : 16'd0);
      chk("onehot_invariant", 16'($countones(req_onehot)), req_valid ? 16'd1 : 16'd0);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n      = 1'b0;
    irq_in     = 16'h0003;
    mask_we    = 1'b0;
    mask_wdata = '0;
    req_ack    = 1'b0;
    tick();
    tick();
    started = 1'b1;
    chk("reset_pending", pending_q, 16'h0000);
    chk("reset_mask", mask_q, 16'h0000);
    chk("reset_valid", {15'd0, req_valid}, 16'd0);
    chk("reset_onehot", req_onehot, 16'h0000);

    // Lines high across reset release must not register as edges.
    rst_n = 1'b1; mask_we = 1'b1; mask_wdata = 16'hFFFF;
    tick();
    mask_we = 1'b0;
    for (int i = 0; i < 10; i++) begin
      chk("held_high_pending", pending_q, 16'h0000);
      chk("held_high_valid", {15'd0, req_valid}, 16'd0);
      tick();
    end
    irq_in = 16'h0000;
    tick();

    // Single pulse on bit 5.
    irq_in = 16'h0020; tick(); irq_in = 16'h0000;
    chk("b5_pending", pending_q, 16'h0020);
    chk("b5_valid_early", {15'd0, req_valid}, 16'd0);
    tick();
    chk("b5_valid", {15'd0, req_valid}, 16'd1);
    chk("b5_onehot", req_onehot, 16'h0020);
    req_ack = 1'b1; tick(); req_ack = 1'b0;
    chk("b5_ack_pending", pending_q, 16'h0000);
    chk("b5_ack_valid", {15'd0, req_valid}, 16'd0);

    // Bits 9 and 2 together: 2 wins, then 9 after an idle cycle.
    irq_in = 16'h0204; tick(); irq_in = 16'h0000; tick();
    chk("pair_first", req_onehot, 16'h0004);
    req_ack = 1'b1; tick(); req_ack = 1'b0;
    chk("pair_gap_valid", {15'd0, req_valid}, 16'd0);
    chk("pair_gap_pending", pending_q, 16'h0200);
    tick();
    chk("pair_second", req_onehot, 16'h0200);

    // Higher-priority arrival while holding does not preempt.
    irq_in = 16'h0001; tick(); irq_in = 16'h0000;
    chk("hold_pending", pending_q, 16'h0201);
    chk("hold_stable1", req_onehot, 16'h0200);
    tick();
    chk("hold_stable2", req_onehot, 16'h0200);
    req_ack = 1'b1; tick(); req_ack = 1'b0;
    chk("hold_gap", {15'd0, req_valid}, 16'd0);
    tick();
    chk("hold_next", req_onehot, 16'h0001);
    req_ack = 1'b1; tick(); req_ack = 1'b0;

    // Masked line latches but waits for the mask.
    mask_we = 1'b1; mask_wdata = 16'hFFF7; tick(); mask_we = 1'b0;
    irq_in = 16'h0008; tick(); irq_in = 16'h0000; tick(); tick();
    chk("masked_pending", pending_q, 16'h0008);
    chk("masked_valid", {15'd0, req_valid}, 16'd0);
    mask_we = 1'b1; mask_wdata = 16'hFFFF; tick(); mask_we = 1'b0;
    chk("unmask_wait", {15'd0, req_valid}, 16'd0);
    tick();
    chk("unmask_onehot", req_onehot, 16'h0008);
    req_ack = 1'b1; tick(); req_ack = 1'b0;

    // Ack and new rise on the same bit: set wins.
    irq_in = 16'h0010; tick(); irq_in = 16'h0000; tick();
    chk("b4_held", req_onehot, 16'h0010);
    irq_in = 16'h0010; req_ack = 1'b1; tick(); irq_in = 16'h0000; req_ack = 1'b0;
    chk("b4_setwins_pending", pending_q, 16'h0010);
    chk("b4_setwins_valid", {15'd0, req_valid}, 16'd0);
    tick();
    chk("b4_represent", req_onehot, 16'h0010);

    // Reset during HOLD.
    rst_n = 1'b0; tick();
    chk("midrst_valid", {15'd0, req_valid}, 16'd0);
    chk("midrst_onehot", req_onehot, 16'h0000);
    chk("midrst_pending", pending_q, 16'h0000);
    chk("midrst_mask", mask_q, 16'h0000);
    rst_n = 1'b1;

    // Randomized traffic.
    for (int c = 0; c < 3000; c++) begin
      irq_in     = irq_in ^ (($urandom_range(0, 3) == 0) ? 16'($urandom) : 16'h0000);
      mask_we    = ($urandom_range(0, 15) == 0);
      mask_wdata = 16'($urandom) | 16'($urandom);
      req_ack    = ($urandom_range(0, 2) == 0);
      rst_n      = ($urandom_range(0, 299) != 0);
      tick();
    end
    rst_n = 1'b1; req_ack = 1'b0; mask_we = 1'b0;
    tick();
    started = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
